seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative signed multiply-add unit: p = q*b + r.
- Inverse of the sequential divider. Rebuilds a dividend from the divider's quotient/remainder for self-checking, and serves as the datapath's general multiplier.
- Uses the same in_en/out_en pulse handshake and error flag style as the divider.
- Radix-2 shift-add on operand magnitudes; sign and addend applied in a final fix-up cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_en  input  1  start request, sampled on rising clk edge while idle
- q  input  WIDTH  signed multiplicand (divider quotient)
- b  input  WIDTH  signed multiplier (divider divisor)
- r  input  WIDTH  signed addend (divider remainder)
- out_en  output  1  one-cycle pulse: p/error valid
- error  output  1  result does not fit WIDTH-bit signed
- p  output  WIDTH  result, low WIDTH bits of q*b+r
- busy  output  1  operation in progress, new requests ignored

Behaviour:
- Reset (rst_n low, async): state=IDLE; out_en=0, error=0, p=0, busy=0; internal count and accumulator cleared. Any in-flight operation is discarded and produces no out_en.
- States: IDLE, RUN, FIX, DONE.
- IDLE: busy=0. If in_en=1 at edge E0:
  - latch q, b, r;
  - store |q| and |b| as WIDTH-bit unsigned (|-2^(WIDTH-1)| = 2^(WIDTH-1) is exact);
  - neg = q[MSB]^b[MSB];
  - acc (2*WIDTH bits) = 0, count = 0;
  - go to RUN.
- RUN: one multiplier bit per cycle.
  - If the current multiplier bit is 1: acc += |q| << count. Then count++.
  - After WIDTH iterations (edge E0+WIDTH) go to FIX.
- FIX: full = (neg ? -acc : acc) + sign-extended r, computed in 2*WIDTH+1 bits.
  - At edge E0+WIDTH+1: p = full[WIDTH-1:0]; error = 1 iff full lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; out_en = 1; go to DONE.
- DONE: out_en is high for exactly this one cycle.
  - At edge E0+WIDTH+2: out_en = 0, go to IDLE.
- Latency and rate:
  - out_en rises WIDTH+1 edges after the accepting edge.
  - Minimum request spacing is WIDTH+3 cycles.
- Hold rules:
  - p and error hold their values until the next FIX.
  - They are not cleared when out_en drops.
- busy = 1 in RUN, FIX and DONE.
- in_en is ignored while busy=1, including during DONE. Operand changes while busy have no effect.
- If in_en is held high continuously, a new operation is accepted on the first edge in IDLE, i.e. back-to-back results every WIDTH+3 cycles.
- b=0 or q=0: the loop still runs the full WIDTH cycles (fixed latency); p = r, error = 0.
- The overflow check covers the combined product-plus-addend. Example: q*b = 2^(WIDTH-1)-1 with r = 1 sets error.

Optional Feature:
- Macro: MULT_DEBUG_PORTS_EN.
- Defined: adds debug outputs matching the divider's observability ports:
  - showcount (WIDTH): iteration counter;
  - showacc (2*WIDTH): accumulator;
  - showactive (1): high in RUN;
  - showstate (2): IDLE=0, RUN=1, FIX=2, DONE=3.
  - All are driven directly from internal registers and reset to 0.
- Undefined: these ports do not exist. Functional behaviour and timing are identical.

Test Plan:
- Default WIDTH. q=-2, b=3, r=0, in_en pulsed at E0 -> out_en high only between E0+33 and E0+34; p=0xFFFFFFFA (-6), error=0.
- q=7, b=2, r=1 -> p=15, error=0. Then q=-3, b=4, r=-1 -> p=-13 (0xFFFFFFF3), error=0.
- q=0x10000, b=0x8000, r=0 -> p=0x80000000, error=1. Then q=-65536, b=32768, r=0 -> p=0x80000000, error=0. Then q=0x7FFFFFFF, b=1, r=1 -> error=1.
- in_en held high, operands changed every cycle -> results every 35 cycles, each matching the operands latched at its accept edge; p/error stable between pulses.
- rst_n driven low for one cycle at E0+10 -> out_en, p, error, busy all 0 immediately, no out_en pulse for the aborted op. A fresh op with q=5, b=-5, r=3 then gives p=-22.
- q=0x12345678, b=0, r=-9 -> p=-9, error=0, latency unchanged at 33 edges.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative signed multiply-add p = q*b + r: radix-2 shift-add on magnitudes, sign/addend fix-up last.
// Define MULT_DEBUG_PORTS_EN to expose showcount/showacc/showactive/showstate observability ports.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_en,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   r,
    output logic               out_en,
    output logic               error,
    output logic [WIDTH-1:0]   p,
    output logic               busy
`ifdef MULT_DEBUG_PORTS_EN
    ,
    output logic [WIDTH-1:0]   showcount,
    output logic [2*WIDTH-1:0] showacc,
    output logic               showactive,
    output logic [1:0]         showstate
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   count_q,  count_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;   // |q| pre-shifted by the iteration count
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // |b| shifted right so bit 0 is the current bit
    logic               neg_q,    neg_d;
    logic [WIDTH-1:0]   r_q,      r_d;
    logic [WIDTH-1:0]   p_q,      p_d;
    logic               error_q,  error_d;
    logic               out_en_q, out_en_d;
    logic               busy_q,   busy_d;
    logic [2*WIDTH:0]   full;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        r_d      = r_q;
        p_d      = p_q;
        error_d  = error_q;
        out_en_d = 1'b0;
        full     = '0;

        case (state_q)
            IDLE: begin
                if (in_en) begin
                    mcand_d  = {{WIDTH{1'b0}}, (q[WIDTH-1] ? -q : q)};
                    mplier_d = b[WIDTH-1] ? -b : b;
                    neg_d    = q[WIDTH-1] ^ b[WIDTH-1];
                    r_d      = r;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + WIDTH'(1);
                if (count_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                full = (neg_q ? -{1'b0, acc_q} : {1'b0, acc_q})
                     + {{(WIDTH+1){r_q[WIDTH-1]}}, r_q};
                p_d  = full[WIDTH-1:0];
                // In range iff every bit from the result sign upward is a copy of it.
                error_d  = !((&full[2*WIDTH:WIDTH-1]) || !(|full[2*WIDTH:WIDTH-1]));
                out_en_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            r_q      <= '0;
            p_q      <= '0;
            error_q  <= 1'b0;
            out_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            r_q      <= r_d;
            p_q      <= p_d;
            error_q  <= error_d;
            out_en_q <= out_en_d;
            busy_q   <= busy_d;
        end
    end

    assign out_en = out_en_q;
    assign error  = error_q;
    assign p      = p_q;
    assign busy   = busy_q;

`ifdef MULT_DEBUG_PORTS_EN
    assign showcount  = count_q;
    assign showacc    = acc_q;
    assign showactive = (state_q == RUN);
    assign showstate  = state_q;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed, random, back-to-back and reset-abort scenarios
// checked against a plain-arithmetic 64-bit model of q*b+r.
module tb_seq_multiplier;

    localparam int WIDTH   = 32;
    localparam int LAT     = WIDTH + 1;
    localparam int SPACING = WIDTH + 3;
    localparam int B2B_CYC = 3 * SPACING + LAT + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_en;
    logic [WIDTH-1:0]  q, b, r, p;
    logic              out_en, error, busy;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] last_p    = '0;
    logic        last_err  = 1'b0;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_en  (in_en),
        .q      (q),
        .b      (b),
        .r      (r),
        .out_en (out_en),
        .error  (error),
        .p      (p),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: exact signed product plus addend in 64-bit arithmetic.
    function automatic void model(input int qi, input int bi, input int ri,
                                  output logic [31:0] pe, output logic ee);
        longint f;
        longint max_v;
        max_v = 64'sd2147483647;
        f  = longint'(qi) * longint'(bi) + longint'(ri);
        pe = f[31:0];
        ee = (f > max_v) || (f < -max_v - 1);
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 2000)) - 32'd1000;
            2: v = $urandom >> 16;
            default: begin
                case ($urandom_range(0, 4))
                    0: v = 32'h8000_0000;
                    1: v = 32'h7FFF_FFFF;
                    2: v = 32'h0000_0000;
                    3: v = 32'h0000_0001;
                    default: v = 32'hFFFF_FFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            total_cnt++;
            $display("FAIL wait_idle: busy=%b, required 0 within 100 cycles", busy);
        end
    endtask

    // Issues one request from idle and observes the response; leaves the bench at a negedge with the DUT idle.
    task automatic do_op(input logic [31:0] qi, input logic [31:0] bi, input logic [31:0] ri,
                         output logic [31:0] po, output logic eo, output int lat,
                         output logic busy_seen, output logic pulse_next, output logic [31:0] p_next);
        wait_idle();
        q = qi; b = bi; r = ri; in_en = 1'b1;
        @(posedge clk);
        #1 in_en = 1'b0;
        q = $urandom; b = $urandom; r = $urandom;
        lat = -1;
        busy_seen = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) busy_seen = busy;
            if (out_en === 1'b1) begin
                lat = i;
                break;
            end
        end
        po = p;
        eo = error;
        @(posedge clk);
        @(negedge clk);
        pulse_next = out_en;
        p_next = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_en = 1'b0; q = '0; b = '0; r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({out_en, error, busy} !== 3'b000 || p !== 32'h0) begin
            $display("FAIL reset_state: out_en=%b error=%b busy=%b p=%h, required 0 0 0 00000000",
                     out_en, error, busy, p);
        end else pass_cnt++;
        rst_n = 1'b1;
        last_p = '0; last_err = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] tq [10];
        logic [31:0] tb_ [10];
        logic [31:0] tr [10];
        logic [31:0] ep, gp, pn;
        logic        ee, ge, bs, pl;
        int          lat;
        tq = '{32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_0000,
               32'h7FFF_FFFF, 32'h1234_5678, 32'h0, 32'h8000_0000, 32'h8000_0000};
        tb_ = '{32'd3, 32'd2, 32'd4, 32'h0000_8000, 32'h0000_8000,
               32'd1, 32'h0, 32'd12345, 32'h8000_0000, 32'hFFFF_FFFF};
        tr = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0,
               32'd1, 32'hFFFF_FFF7, 32'hFFFF_FF00, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            do_op(tq[i], tb_[i], tr[i], gp, ge, lat, bs, pl, pn);
            model(tq[i], tb_[i], tr[i], ep, ee);
            total_cnt++;
            if (gp !== ep) $display("FAIL directed_p[%0d]: got %h, required %h", i, gp, ep);
            else pass_cnt++;
            total_cnt++;
            if (ge !== ee) $display("FAIL directed_err[%0d]: got %b, required %b", i, ge, ee);
            else pass_cnt++;
            total_cnt++;
            if (lat !== LAT) $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, LAT);
            else pass_cnt++;
            total_cnt++;
            if (bs !== 1'b1 || pl !== 1'b0 || busy !== 1'b0)
                $display("FAIL directed_handshake[%0d]: busy_run=%b out_en_next=%b busy_end=%b, required 1 0 0",
                         i, bs, pl, busy);
            else pass_cnt++;
            total_cnt++;
            if (pn !== ep || error !== ee)
                $display("FAIL directed_hold[%0d]: p=%h error=%b, required %h %b", i, pn, error, ep, ee);
            else pass_cnt++;
            last_p = ep; last_err = ee;
        end
    endtask

    task automatic test_random();
        logic [31:0] qi, bi, ri, ep, gp, pn;
        logic        ee, ge, bs, pl;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            qi = rand_operand(); bi = rand_operand(); ri = rand_operand();
            do_op(qi, bi, ri, gp, ge, lat, bs, pl, pn);
            model(qi, bi, ri, ep, ee);
            total_cnt++;
            if (gp !== ep || ge !== ee || lat !== LAT)
                $display("FAIL random[%0d] q=%h b=%h r=%h: p=%h err=%b lat=%0d, required %h %b %0d",
                         i, qi, bi, ri, gp, ge, lat, ep, ee, LAT);
            else pass_cnt++;
            last_p = ep; last_err = ee;
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] ep;
        logic        ee, seen;
        int          lat;
        wait_idle();
        q = 32'd3; b = 32'd3; r = 32'd0; in_en = 1'b1;
        @(posedge clk);
        #1 q = 32'd100; b = 32'd100; r = 32'd100;
        repeat (5) @(posedge clk);
        #1 in_en = 1'b0;
        lat = 5;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_en === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        model(3, 3, 0, ep, ee);
        total_cnt++;
        if (out_en !== 1'b1 || lat !== LAT || p !== ep || error !== ee)
            $display("FAIL busy_ignore_result: out_en=%b lat=%0d p=%h err=%b, required 1 %0d %h %b",
                     out_en, lat, p, error, LAT, ep, ee);
        else pass_cnt++;
        // Request lands on the DONE edge and must be dropped.
        in_en = 1'b1; q = 32'd9; b = 32'd9; r = 32'd9;
        @(posedge clk);
        #1 in_en = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_en === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0 || busy !== 1'b0 || p !== ep)
            $display("FAIL busy_ignore_dropped: extra_pulse=%b busy=%b p=%h, required 0 0 %h", seen, busy, p, ep);
        else pass_cnt++;
        last_p = ep; last_err = ee;
    endtask

    task automatic test_back_to_back();
        logic [31:0] oq [B2B_CYC];
        logic [31:0] ob [B2B_CYC];
        logic [31:0] orr [B2B_CYC];
        logic [31:0] ep;
        logic        ee;
        int          k;
        wait_idle();
        for (int cyc = 0; cyc < B2B_CYC; cyc++) begin
            q = rand_operand(); b = rand_operand(); r = rand_operand();
            oq[cyc] = q; ob[cyc] = b; orr[cyc] = r;
            in_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            k = cyc - LAT;
            total_cnt++;
            if (k >= 0 && (k % SPACING) == 0) begin
                model(oq[k], ob[k], orr[k], ep, ee);
                if (out_en !== 1'b1 || p !== ep || error !== ee)
                    $display("FAIL b2b_result@%0d: out_en=%b p=%h err=%b, required 1 %h %b",
                             cyc, out_en, p, error, ep, ee);
                else pass_cnt++;
                last_p = ep; last_err = ee;
            end else begin
                if (out_en !== 1'b0 || p !== last_p || error !== last_err)
                    $display("FAIL b2b_idle@%0d: out_en=%b p=%h err=%b, required 0 %h %b",
                             cyc, out_en, p, error, last_p, last_err);
                else pass_cnt++;
            end
        end
        in_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] ep, gp, pn;
        logic        ee, ge, bs, pl, seen;
        int          lat;
        wait_idle();
        q = 32'd1234; b = 32'hFFFF_FFB3; r = 32'd5; in_en = 1'b1;
        @(posedge clk);
        #1 in_en = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_en, error, busy} !== 3'b000 || p !== 32'h0)
            $display("FAIL abort_reset_state: out_en=%b error=%b busy=%b p=%h, required 0 0 0 00000000",
                     out_en, error, busy, p);
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_en === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_pulse: pulse seen=%b, required 0", seen);
        else pass_cnt++;
        do_op(32'd5, 32'hFFFF_FFFB, 32'd3, gp, ge, lat, bs, pl, pn);
        model(5, -5, 3, ep, ee);
        total_cnt++;
        if (gp !== ep || ge !== ee || lat !== LAT)
            $display("FAIL abort_fresh_op: p=%h err=%b lat=%0d, required %h %b %0d", gp, ge, lat, ep, ee, LAT);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
